// File: rtl/key_step_pkg.sv
// key_step_pkg: shared state encoding and default sizing for the key step generator
package key_step_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS_CHK   = 2'd1,
      HELD        = 2'd2,
      RELEASE_CHK = 2'd3
   } state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 500000;
   localparam int CNT_W_DEF           = 20;
   localparam int PCNT_W_DEF          = 8;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser, async active-high reset to 0
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // plain two-stage shift, nothing between the flops so the first stage can settle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/key_step_gen.sv
// key_step_gen: synchronise and debounce a push-button into step/release strobes with a captured data bit
module key_step_gen
   import key_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF,
   parameter int PCNT_W          = PCNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              anjian,
   input  logic              x,
   output logic              key_o,
   output logic              step_pulse,
   output logic              x_o,
   output logic              release_pulse,
   output logic [PCNT_W-1:0] press_cnt
);

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

   logic              key_s;
   logic              x_s;
   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              key_q;
   logic              step_q;
   logic              xo_q;
   logic              rel_q;
   logic [PCNT_W-1:0] pcnt_q;
   logic              cnt_done;

   sync_2ff u_sync_key (
      .clk   (clk),
      .reset (reset),
      .d_i   (anjian),
      .q_o   (key_s)
   );

   sync_2ff u_sync_x (
      .clk   (clk),
      .reset (reset),
      .d_i   (x),
      .q_o   (x_s)
   );

   // the stable-sample run that started with cnt=1 reaches DEBOUNCE_CYCLES on this compare
   assign cnt_done = (cnt_q == CNT_LAST);

   // debounce FSM with registered level, strobes, captured data bit and press counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         key_q   <= 1'b0;
         step_q  <= 1'b0;
         xo_q    <= 1'b0;
         rel_q   <= 1'b0;
         pcnt_q  <= '0;
      end else begin
         step_q <= 1'b0;
         rel_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (key_s) begin
                  state_q <= PRESS_CHK;
                  cnt_q   <= CNT_ONE;
               end
            end
            PRESS_CHK: begin
               if (!key_s) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_done) begin
                  state_q <= HELD;
                  cnt_q   <= '0;
                  step_q  <= 1'b1;
                  key_q   <= 1'b1;
                  xo_q    <= x_s;
                  pcnt_q  <= pcnt_q + PCNT_ONE;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            HELD: begin
               if (!key_s) begin
                  state_q <= RELEASE_CHK;
                  cnt_q   <= CNT_ONE;
               end
            end
            RELEASE_CHK: begin
               if (key_s) begin
                  state_q <= HELD;
                  cnt_q   <= '0;
               end else if (cnt_done) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  rel_q   <= 1'b1;
                  key_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign key_o         = key_q;
   assign step_pulse    = step_q;
   assign x_o           = xo_q;
   assign release_pulse = rel_q;
   assign press_cnt     = pcnt_q;

endmodule

// File: tb/tb_key_step_gen.sv
// tb_key_step_gen: table-driven presses with a scoreboard of expected strobes, plus hand-written corner sequences
module tb_key_step_gen;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       anjian = 1'b0;
   logic       x = 1'b0;
   logic       key_o;
   logic       step_pulse;
   logic       x_o;
   logic       release_pulse;
   logic [7:0] press_cnt;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int steps_seen = 0;

   typedef struct {
      int         cyc;
      logic       xv;
      logic [7:0] cnt;
   } step_exp_t;

   typedef struct {
      logic xv;
      int   hi;
      int   lo;
      logic exp_step;
      logic exp_rel;
   } vec_t;

   step_exp_t  step_q[$];
   int         rel_q[$];
   step_exp_t  e_mon;
   int         r_mon;
   logic [7:0] cnt_m = '0;
   logic       last_x_m = 1'b0;
   vec_t       tbl[9];

   key_step_gen #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (20),
      .PCNT_W          (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .anjian        (anjian),
      .x             (x),
      .key_o         (key_o),
      .step_pulse    (step_pulse),
      .x_o           (x_o),
      .release_pulse (release_pulse),
      .press_cnt     (press_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard: every strobe the DUT emits must match the next expectation pushed by the stimulus
   always @(negedge clk) begin
      if (step_pulse || release_pulse)
         chk("strobe_excl", {31'b0, step_pulse & release_pulse}, 0);
      if (step_pulse) begin
         steps_seen++;
         chk("step_pending", 32'(step_q.size() > 0), 1);
         if (step_q.size() > 0) begin
            e_mon = step_q.pop_front();
            chk("step_cyc", cyc, e_mon.cyc);
            chk("x_o", {31'b0, x_o}, {31'b0, e_mon.xv});
            chk("press_cnt", {24'b0, press_cnt}, {24'b0, e_mon.cnt});
            chk("key_o_press", {31'b0, key_o}, 1);
         end
      end
      if (release_pulse) begin
         chk("rel_pending", 32'(rel_q.size() > 0), 1);
         if (rel_q.size() > 0) begin
            r_mon = rel_q.pop_front();
            chk("rel_cyc", cyc, r_mon);
            chk("key_o_release", {31'b0, key_o}, 0);
         end
      end
   end

   task automatic press(input logic xv, input int hi, input int lo, input logic es, input logic er);
      @(posedge clk);
      #1;
      x = xv;
      anjian = 1'b1;
      if (es) begin
         cnt_m = cnt_m + 8'd1;
         last_x_m = xv;
         step_q.push_back('{cyc + D + 2, xv, cnt_m});
      end
      repeat (hi) @(posedge clk);
      #1;
      anjian = 1'b0;
      if (er) rel_q.push_back(cyc + D + 2);
      repeat (lo / 2) @(posedge clk);
      #1;
      x = ~x;
      repeat (lo - lo / 2) @(posedge clk);
      #2;
      chk("key_o_idle", {31'b0, key_o}, 0);
      chk("press_cnt_lvl", {24'b0, press_cnt}, {24'b0, cnt_m});
      chk("x_o_hold", {31'b0, x_o}, {31'b0, last_x_m});
   endtask

   initial begin
      int seen0;
      tbl[0] = '{1'b1, 20, 10, 1'b1, 1'b1};
      tbl[1] = '{1'b0, 3, 8, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 4, 8, 1'b1, 1'b1};
      tbl[3] = '{1'b0, 6, 8, 1'b1, 1'b1};
      tbl[4] = '{1'b1, 6, 8, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 6, 8, 1'b1, 1'b1};
      tbl[6] = '{1'b1, 6, 8, 1'b1, 1'b1};
      tbl[7] = '{1'b1, 6, 8, 1'b1, 1'b1};
      tbl[8] = '{1'b0, 6, 8, 1'b1, 1'b1};

      #12;
      chk("rst_key_o", {31'b0, key_o}, 0);
      chk("rst_step", {31'b0, step_pulse}, 0);
      chk("rst_x_o", {31'b0, x_o}, 0);
      chk("rst_release", {31'b0, release_pulse}, 0);
      chk("rst_press_cnt", {24'b0, press_cnt}, 0);
      @(posedge clk);
      #3;
      reset = 1'b0;

      for (int i = 0; i < 9; i++)
         press(tbl[i].xv, tbl[i].hi, tbl[i].lo, tbl[i].exp_step, tbl[i].exp_rel);

      // bounce rejection: 3 high / 2 low five times, never accepted
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         anjian = 1'b1;
         repeat (3) @(posedge clk);
         #1;
         anjian = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         chk("bounce_key_o", {31'b0, key_o}, 0);
      end
      repeat (10) @(posedge clk);
      #1;
      chk("bounce_press_cnt", {24'b0, press_cnt}, {24'b0, cnt_m});
      chk("bounce_key_o_end", {31'b0, key_o}, 0);

      // release bounce: accepted press, 2-cycle drop rejected, then real release
      x = 1'b1;
      anjian = 1'b1;
      cnt_m = cnt_m + 8'd1;
      last_x_m = 1'b1;
      step_q.push_back('{cyc + D + 2, 1'b1, cnt_m});
      repeat (8) @(posedge clk);
      #1;
      anjian = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      anjian = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("held_key_o", {31'b0, key_o}, 1);
      end
      anjian = 1'b0;
      rel_q.push_back(cyc + D + 2);
      repeat (10) @(posedge clk);
      #2;
      chk("relb_key_o", {31'b0, key_o}, 0);
      chk("relb_x_o", {31'b0, x_o}, 1);

      // async reset while in PRESS_CHK with cnt=2
      @(posedge clk);
      #1;
      anjian = 1'b1;
      repeat (4) @(posedge clk);
      #3;
      reset = 1'b1;
      anjian = 1'b0;
      cnt_m = '0;
      last_x_m = 1'b0;
      #1;
      chk("mid_rst_key_o", {31'b0, key_o}, 0);
      chk("mid_rst_step", {31'b0, step_pulse}, 0);
      chk("mid_rst_x_o", {31'b0, x_o}, 0);
      chk("mid_rst_release", {31'b0, release_pulse}, 0);
      chk("mid_rst_press_cnt", {24'b0, press_cnt}, 0);
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;
      anjian = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      anjian = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("glitch_press_cnt", {24'b0, press_cnt}, 0);
      chk("glitch_key_o", {31'b0, key_o}, 0);

      // wrap: 256 accepted presses bring the counter back to 0
      seen0 = steps_seen;
      for (int i = 0; i < 256; i++)
         press(1'($urandom_range(0, 1)), 5, 6, 1'b1, 1'b1);
      chk("wrap_press_cnt", {24'b0, press_cnt}, 0);
      chk("wrap_steps", steps_seen - seen0, 256);

      repeat (10) @(posedge clk);
      #1;
      chk("step_q_left", step_q.size(), 0);
      chk("rel_q_left", rel_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
